// File: rtl/btn_counter_ctrl.sv
// Push-button counter controller: arbitrates clear/load/inc/dec presses to one
// counter operation per cycle and generates auto-repeat steps while inc/dec is held.
module btn_counter_ctrl #(
  parameter int WIDTH        = 8,
  parameter int REPEAT_DELAY = 25_000_000,
  parameter int REPEAT_RATE  = 5_000_000,
  parameter bit SATURATE     = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_down,
  input  logic             inc_held,
  input  logic             dec_down,
  input  logic             dec_held,
  input  logic             clr_down,
  input  logic             load_down,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] out,
  output logic             step,
  output logic             dropped,
  output logic             at_max,
  output logic             at_min
);

  localparam int TMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam logic [TW-1:0] DLY_LAST  = TW'(REPEAT_DELAY - 1);
  localparam logic [TW-1:0] RATE_LAST = TW'(REPEAT_RATE - 1);

  typedef enum logic [1:0] {S_IDLE, S_DELAY, S_REPEAT} state_t;

  state_t          state;
  logic            owner_dec;
  logic [TW-1:0]   timer;

  logic press_inc, press_dec, both, any_down, drop_any;
  logic owner_held, rpt_fire, rpt_ok, do_inc, do_dec, can_inc, can_dec;

  always_comb begin
    any_down   = inc_down | dec_down | clr_down | load_down;
    both       = inc_down & dec_down;
    press_inc  = inc_down & ~dec_down & ~clr_down & ~load_down;
    press_dec  = dec_down & ~inc_down & ~clr_down & ~load_down;
    // any two simultaneous presses means at least one loses arbitration
    drop_any   = (clr_down & (load_down | inc_down | dec_down)) |
                 (load_down & (inc_down | dec_down)) | both;
    owner_held = owner_dec ? dec_held : inc_held;
    rpt_fire   = owner_held & (((state == S_DELAY) && (timer == DLY_LAST)) ||
                               ((state == S_REPEAT) && (timer == RATE_LAST)));
    rpt_ok     = rpt_fire & ~any_down;
    do_inc     = press_inc | (rpt_ok & ~owner_dec);
    do_dec     = press_dec | (rpt_ok & owner_dec);
    can_inc    = !SATURATE || (out != {WIDTH{1'b1}});
    can_dec    = !SATURATE || (out != '0);
  end

  assign at_max = (out == {WIDTH{1'b1}});
  assign at_min = (out == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      out       <= '0;
      step      <= 1'b0;
      dropped   <= 1'b0;
      state     <= S_IDLE;
      owner_dec <= 1'b0;
      timer     <= '0;
    end else begin
      step    <= 1'b0;
      dropped <= drop_any;
      if (clr_down) begin
        out  <= '0;
        step <= 1'b1;
      end else if (load_down) begin
        out  <= load_val;
        step <= 1'b1;
      end else if (do_inc && can_inc) begin
        out  <= out + WIDTH'(1);
        step <= 1'b1;
      end else if (do_dec && can_dec) begin
        out  <= out - WIDTH'(1);
        step <= 1'b1;
      end

      // a pending repeat step coinciding with clear/load is simply lost
      if (clr_down || load_down || both) begin
        state <= S_IDLE;
        timer <= '0;
      end else if (press_inc || press_dec) begin
        owner_dec <= press_dec;
        state     <= S_DELAY;
        timer     <= '0;
      end else begin
        case (state)
          S_DELAY, S_REPEAT: begin
            if (!owner_held) begin
              state <= S_IDLE;
              timer <= '0;
            end else if (rpt_fire) begin
              state <= S_REPEAT;
              timer <= '0;
            end else begin
              timer <= timer + TW'(1);
            end
          end
          default: begin
            state <= S_IDLE;
            timer <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_btn_counter_ctrl.sv
// Scoreboard bench: a wrapping and a saturating instance share stimulus; a
// countdown-style reference model pushes expected outputs checked after each edge.
module tb_btn_counter_ctrl;
  localparam int W = 8;
  localparam int D = 4;
  localparam int R = 2;

  logic clk = 1'b0;
  logic rst, inc_down, inc_held, dec_down, dec_held, clr_down, load_down;
  logic [W-1:0] load_val;
  logic [W-1:0] out0, out1;
  logic step0, step1, drop0, drop1, max0, max1, min0, min1;

  always #5 clk = ~clk;

  btn_counter_ctrl #(.WIDTH(W), .REPEAT_DELAY(D), .REPEAT_RATE(R), .SATURATE(1'b0)) dut0 (
    .clk(clk), .rst(rst), .inc_down(inc_down), .inc_held(inc_held), .dec_down(dec_down),
    .dec_held(dec_held), .clr_down(clr_down), .load_down(load_down), .load_val(load_val),
    .out(out0), .step(step0), .dropped(drop0), .at_max(max0), .at_min(min0));

  btn_counter_ctrl #(.WIDTH(W), .REPEAT_DELAY(D), .REPEAT_RATE(R), .SATURATE(1'b1)) dut1 (
    .clk(clk), .rst(rst), .inc_down(inc_down), .inc_held(inc_held), .dec_down(dec_down),
    .dec_held(dec_held), .clr_down(clr_down), .load_down(load_down), .load_val(load_val),
    .out(out1), .step(step1), .dropped(drop1), .at_max(max1), .at_min(min1));

  typedef struct packed {
    logic [1:0][W-1:0] o;
    logic [1:0]        s;
    logic              d;
  } exp_t;

  exp_t q[$];
  int n_chk = 0;
  int n_fail = 0;

  // reference model: one repeat engine (saturation does not affect it), two counters
  logic [W-1:0] m_out [2];
  bit m_act, m_odec;
  int m_left;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic tick(input logic r, input logic id, input logic ih, input logic dd,
                      input logic dh, input logic cd, input logic ld, input logic [W-1:0] lv);
    exp_t e, g;
    int npress, dir;
    bit rpt, hold_own;
    rst = r; inc_down = id; inc_held = ih; dec_down = dd; dec_held = dh;
    clr_down = cd; load_down = ld; load_val = lv;
    e = '0;
    if (r) begin
      m_out[0] = '0; m_out[1] = '0;
      m_act = 0; m_odec = 0; m_left = 0;
    end else begin
      npress   = int'(id) + int'(dd) + int'(cd) + int'(ld);
      hold_own = m_odec ? dh : ih;
      rpt      = m_act && hold_own && (m_left == 1);
      e.d      = (npress > 1);
      for (int k = 0; k < 2; k++) begin
        dir = 0;
        if (cd) begin m_out[k] = '0; e.s[k] = 1'b1; end
        else if (ld) begin m_out[k] = lv; e.s[k] = 1'b1; end
        else if (id && dd) dir = 0;
        else if (id) dir = 1;
        else if (dd) dir = -1;
        else if (rpt) dir = m_odec ? -1 : 1;
        if (dir == 1 && !(k == 1 && m_out[k] == 8'hFF)) begin
          m_out[k] = m_out[k] + 8'd1; e.s[k] = 1'b1;
        end
        if (dir == -1 && !(k == 1 && m_out[k] == 8'h00)) begin
          m_out[k] = m_out[k] - 8'd1; e.s[k] = 1'b1;
        end
      end
      if (cd || ld || (id && dd)) m_act = 0;
      else if (id || dd) begin m_act = 1; m_odec = dd; m_left = D; end
      else if (m_act) begin
        if (!hold_own) m_act = 0;
        else if (m_left == 1) m_left = R;
        else m_left--;
      end
    end
    e.o[0] = m_out[0];
    e.o[1] = m_out[1];
    q.push_back(e);
    @(posedge clk);
    #1;
    if (q.size() == 0) begin
      chk("queue_empty", 1, 0);
    end else begin
      g = q.pop_front();
      chk("out0", 32'(out0), 32'(g.o[0]));
      chk("out1", 32'(out1), 32'(g.o[1]));
      chk("step0", 32'(step0), 32'(g.s[0]));
      chk("step1", 32'(step1), 32'(g.s[1]));
      chk("dropped0", 32'(drop0), 32'(g.d));
      chk("dropped1", 32'(drop1), 32'(g.d));
      chk("at_max0", 32'(max0), 32'(g.o[0] == 8'hFF));
      chk("at_max1", 32'(max1), 32'(g.o[1] == 8'hFF));
      chk("at_min0", 32'(min0), 32'(g.o[0] == 8'h00));
      chk("at_min1", 32'(min1), 32'(g.o[1] == 8'h00));
    end
  endtask

  task automatic idle(input int n, input logic ih, input logic dh);
    for (int i = 0; i < n; i++) tick(0, 0, ih, 0, dh, 0, 0, 8'h00);
  endtask

  initial begin
    logic ih, dh;
    rst = 1; inc_down = 0; inc_held = 0; dec_down = 0; dec_held = 0;
    clr_down = 0; load_down = 0; load_val = '0;
    tick(1, 0, 0, 0, 0, 0, 0, 8'h00);
    tick(1, 0, 0, 0, 0, 0, 0, 8'h00);

    // single presses, no hold
    for (int i = 0; i < 3; i++) begin
      tick(0, 1, 0, 0, 0, 0, 0, 8'h00);
      idle(2, 0, 0);
    end

    // hold inc: press at c0, held through c9, released at c10
    tick(0, 0, 0, 0, 0, 1, 0, 8'h00);
    tick(0, 1, 1, 0, 0, 0, 0, 8'h00);
    idle(9, 1, 0);
    idle(6, 0, 0);

    // wrap vs clamp at max, and at min
    tick(0, 0, 0, 0, 0, 0, 1, 8'hFF);
    tick(0, 1, 0, 0, 0, 0, 0, 8'h00);
    tick(0, 0, 0, 0, 0, 1, 0, 8'h00);
    tick(0, 0, 0, 1, 0, 0, 0, 8'h00);
    idle(2, 0, 0);

    // clear + load + inc together from 7, then load alone
    tick(0, 0, 0, 0, 0, 0, 1, 8'h07);
    tick(0, 1, 0, 0, 0, 1, 1, 8'h5A);
    tick(0, 0, 0, 0, 0, 0, 1, 8'h5A);

    // dec hold into REPEAT, re-press dec unheld, then inc held, then inc+dec
    tick(0, 0, 0, 1, 1, 0, 0, 8'h00);
    idle(8, 0, 1);
    tick(0, 0, 0, 1, 0, 0, 0, 8'h00);
    idle(4, 0, 0);
    tick(0, 1, 1, 0, 0, 0, 0, 8'h00);
    idle(7, 1, 0);
    tick(0, 1, 1, 1, 0, 0, 0, 8'h00);
    idle(6, 1, 0);

    // reset mid-repeat with inc still held; no restart without a new press
    tick(0, 1, 1, 0, 0, 0, 0, 8'h00);
    idle(7, 1, 0);
    tick(1, 0, 1, 0, 0, 0, 0, 8'h00);
    idle(10, 1, 0);
    tick(0, 1, 1, 0, 0, 0, 0, 8'h00);
    idle(6, 1, 0);

    // random traffic with sticky held levels
    ih = 0; dh = 0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) == 0) ih = ~ih;
      if ($urandom_range(0, 9) == 0) dh = ~dh;
      tick($urandom_range(0, 99) == 0,
           $urandom_range(0, 9) == 0, ih,
           $urandom_range(0, 9) == 0, dh,
           $urandom_range(0, 29) == 0,
           $urandom_range(0, 19) == 0,
           8'($urandom_range(0, 255)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/btn_counter_ctrl.md
# btn_counter_ctrl

Command controller for the push-button counter datapath. It takes debounced single-cycle press pulses and held levels from up to four button channels: increment, decrement, clear and load. It arbitrates them to one counter operation per clock and generates auto-repeat steps while an increment or decrement button is held. It owns the count register and sits directly behind the per-button debounce instances, driving the LED/display output bus.

## Interface
Parameters:
- WIDTH, 8, count register width in bits
- REPEAT_DELAY, 25_000_000, cycles from initial step to first auto-repeat step (>=1)
- REPEAT_RATE, 5_000_000, cycles between subsequent auto-repeat steps (>=1)
- SATURATE, 0, 0 = wrap at 0 / 2^WIDTH-1; 1 = clamp at those bounds

Ports:
- clk  in  1  single system clock; all logic on posedge
- rst  in  1  synchronous, active-high reset
- inc_down  in  1  one-cycle press pulse, increment button
- inc_held  in  1  debounced level, increment button pressed
- dec_down  in  1  one-cycle press pulse, decrement button
- dec_held  in  1  debounced level, decrement button pressed
- clr_down  in  1  one-cycle press pulse, clear button
- load_down  in  1  one-cycle press pulse, load button
- load_val  in  WIDTH  value written on accepted load; sampled the same cycle as load_down
- out  out  WIDTH  registered count
- step  out  1  registered pulse; high the cycle `out` shows a value written by an accepted command
- dropped  out  1  registered pulse; one or more press pulses were discarded that cycle
- at_max  out  1  combinational, out == 2^WIDTH-1
- at_min  out  1  combinational, out == 0

## Operation
- Exactly one command is applied per cycle. Fixed priority: clr_down > load_down > inc_down/dec_down > auto-repeat step.
- Press pulses that lose arbitration are discarded, not queued, and assert `dropped` next cycle.
- inc_down and dec_down together with no clr/load: no change, no step, `dropped`=1, repeat FSM goes to IDLE.
- Clear writes 0. Load writes load_val. Inc/dec add or subtract 1 modulo 2^WIDTH.
- If SATURATE=1, inc at max or dec at 0 leaves `out` unchanged with `step`=0. This is not a drop.
- Repeat FSM states: IDLE, DELAY, REPEAT. It has a direction owner (INC/DEC) and a timer sized for max(REPEAT_DELAY, REPEAT_RATE).
  - Any state, accepted inc_down or dec_down: owner = that direction, timer = 0, go to DELAY. This includes a switch of direction.
  - DELAY: timer increments each cycle. At timer == REPEAT_DELAY-1, issue a repeat step, timer = 0, go to REPEAT.
  - REPEAT: at timer == REPEAT_RATE-1, issue a repeat step, timer = 0.
  - In DELAY or REPEAT, owner's *_held low: go to IDLE. No step is issued that cycle.
  - Accepted clear or load: go to IDLE. A repeat step coinciding with clear/load is lost silently (no `dropped`).
  - The non-owner *_held level is ignored.
- A repeat step is an inc or dec in the owner's direction. It obeys the SATURATE rule. In saturate mode the FSM keeps running at the bound.

## Timing
- Reset values: out=0, step=0, dropped=0, FSM=IDLE, owner=INC, timer=0. at_min=1, at_max=0 follow from out=0.
- Latency: a command accepted in cycle N shows on `out` and `step` in cycle N+1. `dropped` for cycle N shows in N+1.
- With a button pressed in cycle N and held, `out` changes at:
  - N+1 (the press)
  - N+1+REPEAT_DELAY (first repeat)
  - then every REPEAT_RATE cycles.
- Release takes effect the cycle *_held is low; no step is issued in or after that cycle.
- rst asserted mid-repeat returns to reset values next cycle. A still-high *_held does not restart repeat; a fresh *_down is required.
- rst has priority over every input in the same cycle.

## Test plan
- Reset, then inc_down pulse with inc_held low, three times -> out 0→1→2→3, each one cycle after its pulse, step high each time.
- REPEAT_DELAY=4, REPEAT_RATE=2: inc_down at cycle 0 with inc_held high through cycle 9, low at 10 -> out=1@1, 2@5, 3@7, 4@9, no change after.
- WIDTH=8, SATURATE=0, out=255, inc_down -> out=0, at_min=1. SATURATE=1, out=255, inc_down -> out=255, step=0, dropped=0.
- clr_down, load_down (load_val=0x5A) and inc_down in the same cycle, from out=7 -> out=0, step=1, dropped=1. load alone next -> out=0x5A.
- Holding dec in REPEAT, dec_down pulse with dec_held low -> FSM to IDLE; then inc_down with inc_held high -> owner INC, repeat increments from DELAY; inc_down+dec_down together -> no change, dropped=1.
- rst asserted in REPEAT with inc_held still high -> out=0 next cycle, no further steps until a new inc_down.
